// File: rtl/mod_counter_if.sv
// mod_counter_if: control/status bundle for the modulus-N phase counter.
//
// Signals:
//   Clear      - synchronous clear to 0 (active-high)
//   Load       - synchronous parallel load (active-high)
//   Load_value - value taken on Load, clamped to MODULUS-1 by the counter
//   Count      - count enable (active-high)
//   Up         - direction: 1 = increment, 0 = decrement
//   Q          - current count (registered)
//   Tc         - terminal count (combinational from Q, Up and Count)
//   Wrap       - one-cycle pulse after a wrap-around (registered)
//
// Modports:
//   master - phase controller side: drives the controls, observes the status
//   slave  - counter side: takes the controls, drives the status
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             Clear;
  logic             Load;
  logic [WIDTH-1:0] Load_value;
  logic             Count;
  logic             Up;
  logic [WIDTH-1:0] Q;
  logic             Tc;
  logic             Wrap;

  modport master (
    output Clear, Load, Load_value, Count, Up,
    input  Q, Tc, Wrap
  );

  modport slave (
    input  Clear, Load, Load_value, Count, Up,
    output Q, Tc, Wrap
  );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: parametrised modulus-N up/down counter for traffic-light
// phase timing. Counts in 0..MODULUS-1, either wrapping (SATURATE=0) or
// holding (SATURATE=1) at the range ends.
//
// Parameters:
//   WIDTH    - counter width in bits (1..16)
//   MODULUS  - count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE - 0 = wrap at range ends, 1 = hold at range ends
//
// Ports:
//   Clk     - rising-edge clock
//   Reset_n - asynchronous active-low reset; clears Q and Wrap
//   bus     - mod_counter_if.slave (Clear, Load, Load_value, Count, Up in;
//             Q, Tc, Wrap out)
//
// Edge priority: Clear > Load > Count > hold.
module mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic         Clk,
  input  logic         Reset_n,
  mod_counter_if.slave bus
);

  if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 1..16");
  end
  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MIN_Q = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // Out-of-range load values are pulled down to the top of the range so Q
  // can never leave 0..MODULUS-1.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  // Increment at the range end either wraps to 0 or saturates at MAX_Q.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] q);
    if (q == MAX_Q) begin
      return (SATURATE != 0) ? MAX_Q : MIN_Q;
    end
    return q + ONE;
  endfunction

  // Decrement at 0 either wraps to MAX_Q or saturates at 0.
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] q);
    if (q == MIN_Q) begin
      return (SATURATE != 0) ? MIN_Q : MAX_Q;
    end
    return q - ONE;
  endfunction

  logic [WIDTH-1:0] q_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_min;

  assign at_max = (q_p0 == MAX_Q);
  assign at_min = (q_p0 == MIN_Q);

  always_comb begin
    q_nxt    = q_p0;
    wrap_nxt = 1'b0;
    if (bus.Clear) begin
      q_nxt = MIN_Q;
    end else if (bus.Load) begin
      q_nxt = clamp_load(bus.Load_value);
    end else if (bus.Count) begin
      if (bus.Up) begin
        q_nxt    = step_up(q_p0);
        wrap_nxt = at_max && (SATURATE == 0);
      end else begin
        q_nxt    = step_down(q_p0);
        wrap_nxt = at_min && (SATURATE == 0);
      end
    end
  end

  // ---- stage p0: count and wrap-event registers ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_p0    <= '0;
      wrap_p0 <= 1'b0;
    end else begin
      q_p0    <= q_nxt;
      wrap_p0 <= wrap_nxt;
    end
  end

  // Tc anticipates the edge that would wrap or saturate, so it must follow
  // Count/Up combinationally rather than being registered.
  assign bus.Q    = q_p0;
  assign bus.Wrap = wrap_p0;
  assign bus.Tc   = bus.Count & ((bus.Up & at_max) | (~bus.Up & at_min));

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  typedef struct packed {
    logic [2:0][15:0] q;
    logic [2:0]       w;
    logic [2:0]       t;
  } item_t;

  logic       Clk;
  logic       Reset_n;
  logic       clr, ld, cnt, up;
  logic [3:0] lv;

  int checks   = 0;
  int failures = 0;

  item_t sb[$];

  int mods[3] = '{10, 10, 16};
  int sats[3] = '{0, 1, 0};
  int mq[3]   = '{0, 0, 0};

  mod_counter_if #(.WIDTH(4)) if0 ();
  mod_counter_if #(.WIDTH(4)) if1 ();
  mod_counter_if #(.WIDTH(4)) if2 ();

  assign if0.Clear = clr; assign if0.Load = ld; assign if0.Load_value = lv;
  assign if0.Count = cnt; assign if0.Up = up;
  assign if1.Clear = clr; assign if1.Load = ld; assign if1.Load_value = lv;
  assign if1.Count = cnt; assign if1.Up = up;
  assign if2.Clear = clr; assign if2.Load = ld; assign if2.Load_value = lv;
  assign if2.Count = cnt; assign if2.Up = up;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if0));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if1));
  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if2));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: counting in modular arithmetic over 0..mod-1.
  function automatic void model_step(input int q, input int m, input int sat,
                                     input bit c, input bit l, input int v,
                                     input bit n, input bit u,
                                     output int qn, output bit w);
    qn = q;
    w  = 1'b0;
    if (c) qn = 0;
    else if (l) qn = (v < m) ? v : m - 1;
    else if (n) begin
      int target;
      bit at_end;
      target = u ? (q + 1) % m : (q + m - 1) % m;
      at_end = u ? (q == m - 1) : (q == 0);
      if (at_end && sat != 0) qn = q;
      else begin
        qn = target;
        w  = at_end;
      end
    end
  endfunction

  task automatic drive(input bit c, input bit l, input int v, input bit n, input bit u);
    item_t it;
    int    qn;
    bit    w;
    @(negedge Clk);
    clr = c; ld = l; lv = v[3:0]; cnt = n; up = u;
    it = '0;
    for (int i = 0; i < 3; i++) begin
      model_step(mq[i], mods[i], sats[i], c, l, v, n, u, qn, w);
      mq[i]   = qn;
      it.q[i] = 16'(qn);
      it.w[i] = w;
      it.t[i] = n & (u ? (qn == mods[i] - 1) : (qn == 0));
    end
    sb.push_back(it);
  endtask

  // Monitor: one expected item per active edge carrying stimulus.
  initial begin
    item_t it;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("q_m10_wrap", {12'd0, if0.Q}, it.q[0]);
        chk("q_m10_sat",  {12'd0, if1.Q}, it.q[1]);
        chk("q_m16_wrap", {12'd0, if2.Q}, it.q[2]);
        chk("wrap_m10_wrap", {15'd0, if0.Wrap}, {15'd0, it.w[0]});
        chk("wrap_m10_sat",  {15'd0, if1.Wrap}, {15'd0, it.w[1]});
        chk("wrap_m16_wrap", {15'd0, if2.Wrap}, {15'd0, it.w[2]});
        chk("tc_m10_wrap", {15'd0, if0.Tc}, {15'd0, it.t[0]});
        chk("tc_m10_sat",  {15'd0, if1.Tc}, {15'd0, it.t[1]});
        chk("tc_m16_wrap", {15'd0, if2.Tc}, {15'd0, it.t[2]});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q0"}, {12'd0, if0.Q}, 16'd0);
    chk({tag, "_q1"}, {12'd0, if1.Q}, 16'd0);
    chk({tag, "_q2"}, {12'd0, if2.Q}, 16'd0);
    chk({tag, "_w0"}, {15'd0, if0.Wrap}, 16'd0);
    chk({tag, "_w1"}, {15'd0, if1.Wrap}, 16'd0);
    chk({tag, "_w2"}, {15'd0, if2.Wrap}, 16'd0);
  endtask

  initial begin
    bit rc, rl, rn, ru;
    clr = 0; ld = 0; lv = 0; cnt = 0; up = 1;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("reset_init");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Up count across a full period, then down across zero.
    repeat (10) drive(0, 0, 0, 1, 1);
    repeat (3)  drive(0, 0, 0, 1, 0);

    // Bring counters to 7, then reset asynchronously between edges.
    drive(0, 1, 0, 0, 1);
    repeat (7) drive(0, 0, 0, 1, 1);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    clr = 0; ld = 0; cnt = 0; up = 1;
    for (int i = 0; i < 3; i++) mq[i] = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) drive(0, 0, 0, 1, 1);

    // Range ends: saturating counter holds, wrapping ones wrap.
    drive(0, 1, 9, 0, 1);
    repeat (3) drive(0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0);

    // Load and clamp, load beats count.
    drive(0, 1, 4, 0, 1);
    drive(0, 1, 13, 0, 1);
    drive(0, 1, 13, 1, 1);
    drive(0, 1, 4, 1, 0);
    drive(0, 1, 15, 1, 1);
    drive(0, 0, 0, 1, 1);

    // Clear beats load and count, then hold.
    drive(0, 1, 5, 0, 1);
    drive(1, 1, 3, 1, 1);
    repeat (5) drive(0, 0, 0, 0, 1);

    // Randomised traffic with a sticky direction.
    ru = 1;
    for (int k = 0; k < 1500; k++) begin
      rc = ($urandom_range(0, 99) < 3);
      rl = ($urandom_range(0, 99) < 8);
      rn = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 99) < 20) ru = ~ru;
      drive(rc, rl, int'($urandom_range(0, 15)), rn, ru);
    end
    drive(0, 0, 0, 0, 1);

    repeat (4) @(posedge Clk);
    #2;
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
